// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch program-counter generator with trap, redirect, stall and
//            buffered-redirect handling. Build macro RVC_EN enables
//            compressed (2-byte) increment and halfword target alignment.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             inst_compressed,
    input  logic             redir_valid,
    input  logic [XLEN-1:0]  redir_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vector,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redir_cnt
);

`ifdef RVC_EN
    localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};
`else
    localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [XLEN-1:0]  r_pc;
    logic             r_valid;
    logic             r_flush;
    logic             r_mis;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_valid;
    logic [XLEN-1:0]  r_pend_target;

    logic             w_apply;
    logic             w_capture;
    logic             w_pend_clr;
    logic [XLEN-1:0]  w_raw_target;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_inc;
    logic             w_mis;

`ifdef RVC_EN
    assign w_inc = inst_compressed ? XLEN'(2) : XLEN'(4);
    assign w_mis = 1'b0;
`else
    logic w_unused_compressed;
    assign w_unused_compressed = inst_compressed;
    assign w_inc = XLEN'(4);
    assign w_mis = w_raw_target[1];
`endif

    // Next-PC selection; the first edge after reset only raises pc_valid.
    always_comb begin
        w_apply      = 1'b0;
        w_capture    = 1'b0;
        w_pend_clr   = 1'b0;
        w_raw_target = '0;
        w_next_pc    = r_pc;
        if (!r_valid) begin
            w_next_pc = r_pc;
        end else if (trap_valid) begin
            w_apply      = 1'b1;
            w_pend_clr   = 1'b1;
            w_raw_target = trap_vector;
        end else if (stall) begin
            w_capture = redir_valid;
        end else if (r_pend_valid) begin
            w_apply      = 1'b1;
            w_pend_clr   = 1'b1;
            w_raw_target = redir_valid ? redir_target : r_pend_target;
        end else if (redir_valid) begin
            w_apply      = 1'b1;
            w_raw_target = redir_target;
        end else begin
            w_next_pc = r_pc + w_inc;
        end
        if (w_apply) begin
            w_next_pc = w_raw_target & C_ALIGN_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_valid       <= 1'b0;
            r_flush       <= 1'b0;
            r_mis         <= 1'b0;
            r_cnt         <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_valid <= 1'b1;
            r_pc    <= w_next_pc;
            r_flush <= w_apply;
            if (w_apply) begin
                r_mis <= w_mis;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_capture) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= redir_target;
            end else if (w_pend_clr) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

    assign pc_out       = r_pc;
    assign pc_valid     = r_valid;
    assign flush        = r_flush;
    assign misalign_err = r_mis;
    assign redir_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed-vector scoreboard bench for pc_gen (CNT_W=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    typedef struct {
        int               id;
        logic [XLEN-1:0]  pc;
        logic             v;
        logic             f;
        logic             m;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             inst_compressed;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_target;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_vector;
    logic [XLEN-1:0]  pc_out;
    logic             pc_valid;
    logic             flush;
    logic             misalign_err;
    logic [CNT_W-1:0] redir_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN        (XLEN),
        .RESET_VECTOR(32'h0000_0000),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .inst_compressed(inst_compressed),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .misalign_err   (misalign_err),
        .redir_cnt      (redir_cnt)
    );

    // Monitor: every cycle with an outstanding expectation is compared.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks += 5;
            if (pc_out !== e.pc) begin
                n_fail++;
                $display("FAIL vec%0d pc_out: got %h want %h", e.id, pc_out, e.pc);
            end
            if (pc_valid !== e.v) begin
                n_fail++;
                $display("FAIL vec%0d pc_valid: got %b want %b", e.id, pc_valid, e.v);
            end
            if (flush !== e.f) begin
                n_fail++;
                $display("FAIL vec%0d flush: got %b want %b", e.id, flush, e.f);
            end
            if (misalign_err !== e.m) begin
                n_fail++;
                $display("FAIL vec%0d misalign_err: got %b want %b", e.id, misalign_err, e.m);
            end
            if (redir_cnt !== e.c) begin
                n_fail++;
                $display("FAIL vec%0d redir_cnt: got %0d want %0d", e.id, redir_cnt, e.c);
            end
        end
    end

    task automatic cyc(
        input logic             i_rst,
        input logic             i_stall,
        input logic             i_rv,
        input logic [XLEN-1:0]  i_rt,
        input logic             i_tv,
        input logic [XLEN-1:0]  i_vec,
        input logic             i_comp,
        input logic [XLEN-1:0]  e_pc,
        input logic             e_v,
        input logic             e_f,
        input logic             e_m,
        input logic [CNT_W-1:0] e_c
    );
        exp_t e;
        rst             = i_rst;
        stall           = i_stall;
        redir_valid     = i_rv;
        redir_target    = i_rt;
        trap_valid      = i_tv;
        trap_vector     = i_vec;
        inst_compressed = i_comp;
        vec_id++;
        e.id = vec_id; e.pc = e_pc; e.v = e_v; e.f = e_f; e.m = e_m; e.c = e_c;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; inst_compressed = 1'b0;
        redir_valid = 1'b0; redir_target = '0; trap_valid = 1'b0; trap_vector = '0;
        @(negedge clk);
        #1;
        //  rst stl rv rt            tv vec           cmp  pc             v  f  m  c
        // Reset and free-run
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,         0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,         0, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,         1, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h4,         1, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h8,         1, 0, 0, 0);
        // Plain redirect
        cyc(0, 0, 1, 32'h100,      0, 32'h0,        0,   32'h100,       1, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h104,       1, 0, 0, 1);
        cyc(0, 0, 1, 32'h20,       0, 32'h0,        0,   32'h20,        1, 1, 0, 2);
        // Stall with two buffered redirects, newest wins on release
        cyc(0, 1, 1, 32'h400,      0, 32'h0,        0,   32'h20,        1, 0, 0, 2);
        cyc(0, 1, 1, 32'h500,      0, 32'h0,        0,   32'h20,        1, 0, 0, 2);
        cyc(0, 1, 0, 32'h0,        0, 32'h0,        0,   32'h20,        1, 0, 0, 2);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h500,       1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h504,       1, 0, 0, 3);
        // Trap during stall discards pending; counter already saturated
        cyc(0, 1, 1, 32'h300,      0, 32'h0,        0,   32'h504,       1, 0, 0, 3);
        cyc(0, 1, 0, 32'h0,        1, 32'h80,       0,   32'h80,        1, 1, 0, 3);
        cyc(0, 1, 0, 32'h0,        0, 32'h0,        0,   32'h80,        1, 0, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h84,        1, 0, 0, 3);
        // New redirect on release overrides pending target
        cyc(0, 1, 1, 32'h600,      0, 32'h0,        0,   32'h84,        1, 0, 0, 3);
        cyc(0, 0, 1, 32'h700,      0, 32'h0,        0,   32'h700,       1, 1, 0, 3);
        // Wrap-around
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0,   32'hFFFF_FFFC, 1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,         1, 0, 0, 3);
`ifdef RVC_EN
        cyc(0, 0, 1, 32'h102,      0, 32'h0,        0,   32'h102,       1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1,   32'h104,       1, 0, 0, 3);
        cyc(0, 0, 1, 32'h200,      0, 32'h0,        0,   32'h200,       1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        1, 32'h43,       0,   32'h42,        1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h46,        1, 0, 0, 3);
`else
        cyc(0, 0, 1, 32'h102,      0, 32'h0,        0,   32'h100,       1, 1, 1, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        1,   32'h104,       1, 0, 1, 3);
        cyc(0, 0, 1, 32'h200,      0, 32'h0,        0,   32'h200,       1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        1, 32'h43,       0,   32'h40,        1, 1, 1, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h44,        1, 0, 1, 3);
`endif
        // Back-to-back redirects keep flush high
        cyc(0, 0, 1, 32'h800,      0, 32'h0,        0,   32'h800,       1, 1, 0, 3);
        cyc(0, 0, 1, 32'h900,      0, 32'h0,        0,   32'h900,       1, 1, 0, 3);
        // Reset overrides trap/stall and drops pending redirect
        cyc(0, 1, 1, 32'hA00,      0, 32'h0,        0,   32'h900,       1, 0, 0, 3);
        cyc(1, 1, 0, 32'h0,        1, 32'h80,       0,   32'h0,         0, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h0,         1, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h4,         1, 0, 0, 0);
        // Counter saturation at 3
        cyc(0, 0, 1, 32'h10,       0, 32'h0,        0,   32'h10,        1, 1, 0, 1);
        cyc(0, 0, 1, 32'h20,       0, 32'h0,        0,   32'h20,        1, 1, 0, 2);
        cyc(0, 0, 1, 32'h30,       0, 32'h0,        0,   32'h30,        1, 1, 0, 3);
        cyc(0, 0, 1, 32'h40,       0, 32'h0,        0,   32'h40,        1, 1, 0, 3);
        cyc(0, 0, 1, 32'h50,       0, 32'h0,        0,   32'h50,        1, 1, 0, 3);
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0,   32'h54,        1, 0, 0, 3);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
